mb_sequenciador: RTL

- Transaction controller for the Multibanco ATM datapath.
- Sequences card insertion, PIN check with retry limit, and the operation menu (withdrawal, payment, balance inquiry).
- Owns the account balance register and the inactivity timeout.
- Drives the screen message code, balance, value, code and parity outputs that feed the BCD display decoders.

---
 rtl/mb_sequenciador.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mb_sequenciador.sv
// mb_sequenciador: Multibanco ATM transaction controller (card, PIN, menu, balance, timeout).
module mb_sequenciador #(
    parameter logic [4:0] PIN_REF   = 5'd10,
    parameter logic [4:0] SALDO_INI = 5'd15,
    parameter logic [1:0] MAX_TENT  = 2'd3,
    parameter int         TMO_CYC   = 16,
    parameter int         MSG_CYC   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CARD_IN,
    input  logic       ENTER,
    input  logic [1:0] OP,
    input  logic [4:0] PIN,
    input  logic [4:0] VAL,
    input  logic [5:0] COD,
    output logic [3:0] ECRA,
    output logic [4:0] SALDO,
    output logic [4:0] VAL_OUT,
    output logic [5:0] COD_OUT,
    output logic       PAR_OUT,
    output logic       DISPENSE,
    output logic       BLOQ
);
    localparam int TW = $clog2(TMO_CYC);
    localparam int MW = $clog2(MSG_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_PIN, S_MENU, S_LEV, S_PAG, S_MSG, S_BLOQ} state_t;

    state_t st_q, st_d;
    logic [3:0] ecra_q, ecra_d, msg_q, msg_d;
    logic [4:0] saldo_q, saldo_d, val_q, val_d;
    logic [5:0] cod_q, cod_d;
    logic par_q, par_d, disp_q, disp_d, bloq_q, bloq_d;
    logic [1:0] att_q, att_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic timed, tmo_hit, bad_val, card_out;

    always_comb begin
        st_d     = st_q;
        msg_d    = msg_q;
        saldo_d  = saldo_q;
        val_d    = val_q;
        cod_d    = cod_q;
        par_d    = par_q;
        disp_d   = 1'b0;
        att_d    = att_q;
        timed    = st_q == S_PIN || st_q == S_MENU || st_q == S_LEV || st_q == S_PAG;
        tmo_hit  = timed && !ENTER && tmo_q == TW'(TMO_CYC - 1);
        card_out = st_q != S_IDLE && st_q != S_BLOQ && !CARD_IN;
        bad_val  = VAL == 5'd0 || VAL > saldo_q;
        if (card_out) begin
            st_d  = S_IDLE;
            att_d = 2'd0;
        end else if (tmo_hit) begin
            st_d  = S_MSG;
            msg_d = 4'd9;
            att_d = 2'd0;
        end else begin
            case (st_q)
                S_IDLE: begin
                    att_d = 2'd0;
                    if (CARD_IN) st_d = S_PIN;
                end
                S_PIN: if (ENTER) begin
                    if (PIN == PIN_REF) begin
                        st_d  = S_MENU;
                        att_d = 2'd0;
                    end else begin
                        att_d = att_q + 2'd1;
                        st_d  = (att_q + 2'd1 == MAX_TENT) ? S_BLOQ : S_MSG;
                        msg_d = 4'd2;
                    end
                end
                S_MENU: if (ENTER) begin
                    st_d  = OP == 2'd0 ? S_LEV : OP == 2'd1 ? S_PAG : OP == 2'd2 ? S_MSG : S_IDLE;
                    msg_d = 4'd10;
                end
                S_LEV: if (ENTER) begin
                    st_d  = S_MSG;
                    msg_d = bad_val ? 4'd7 : 4'd6;
                    if (!bad_val) begin
                        saldo_d = saldo_q - VAL;
                        val_d   = VAL;
                        disp_d  = 1'b1;
                    end
                end
                S_PAG: if (ENTER) begin
                    st_d  = S_MSG;
                    msg_d = (bad_val || COD == 6'd0) ? 4'd7 : 4'd6;
                    if (!bad_val && COD != 6'd0) begin
                        saldo_d = saldo_q - VAL;
                        val_d   = VAL;
                        cod_d   = COD;
                        par_d   = ^COD;
                    end
                end
                S_MSG: if (mcnt_q == MW'(MSG_CYC - 1))
                    st_d = msg_q == 4'd2 ? S_PIN : msg_q == 4'd9 ? S_IDLE : S_MENU;
                default: ;
            endcase
        end
        // Both counters restart whenever the state changes, so each state starts from zero
        tmo_d  = (st_d != st_q || ENTER) ? '0 : tmo_q + 1'b1;
        mcnt_d = (st_d != st_q) ? '0 : mcnt_q + 1'b1;
        ecra_d = st_d == S_PIN  ? 4'd1 :
                 st_d == S_MENU ? 4'd3 :
                 st_d == S_LEV  ? 4'd4 :
                 st_d == S_PAG  ? 4'd5 :
                 st_d == S_MSG  ? msg_d :
                 st_d == S_BLOQ ? 4'd8 : 4'd0;
        bloq_d = bloq_q || st_d == S_BLOQ;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q    <= S_IDLE;
            ecra_q  <= 4'd0;
            msg_q   <= 4'd0;
            saldo_q <= SALDO_INI;
            val_q   <= 5'd0;
            cod_q   <= 6'd0;
            par_q   <= 1'b0;
            disp_q  <= 1'b0;
            bloq_q  <= 1'b0;
            att_q   <= 2'd0;
            tmo_q   <= '0;
            mcnt_q  <= '0;
        end else begin
            st_q    <= st_d;
            ecra_q  <= ecra_d;
            msg_q   <= msg_d;
            saldo_q <= saldo_d;
            val_q   <= val_d;
            cod_q   <= cod_d;
            par_q   <= par_d;
            disp_q  <= disp_d;
            bloq_q  <= bloq_d;
            att_q   <= att_d;
            tmo_q   <= tmo_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign ECRA     = ecra_q;
    assign SALDO    = saldo_q;
    assign VAL_OUT  = val_q;
    assign COD_OUT  = cod_q;
    assign PAR_OUT  = par_q;
    assign DISPENSE = disp_q;
    assign BLOQ     = bloq_q;
endmodule
